// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction fetch stage and the ALU pipeline.
// - Instruction word layout {func, rd, rs1, rs2, addr} and field widths.
// - HALT_FUNC: func code that terminates a program.
// - Fetch FSM state encoding.
// - ALU func codes 0..11.
package pipe_pkg;

  localparam int unsigned IW     = 24;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned ADDR_W = 8;

  localparam int unsigned FUNC_HI = 23;
  localparam int unsigned FUNC_LO = 20;
  localparam int unsigned RD_HI   = 19;
  localparam int unsigned RD_LO   = 16;
  localparam int unsigned RS1_HI  = 15;
  localparam int unsigned RS1_LO  = 12;
  localparam int unsigned RS2_HI  = 11;
  localparam int unsigned RS2_LO  = 8;
  localparam int unsigned ADDR_HI = 7;
  localparam int unsigned ADDR_LO = 0;

  localparam logic [FUNC_W-1:0] HALT_FUNC = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } fetch_state_e;

  typedef enum logic [3:0] {
    FuncAdd   = 4'd0,
    FuncSub   = 4'd1,
    FuncAnd   = 4'd2,
    FuncOr    = 4'd3,
    FuncXor   = 4'd4,
    FuncShl   = 4'd5,
    FuncShr   = 4'd6,
    FuncSra   = 4'd7,
    FuncSlt   = 4'd8,
    FuncSltu  = 4'd9,
    FuncLoad  = 4'd10,
    FuncStore = 4'd11
  } alu_func_e;

  function automatic logic [FUNC_W-1:0] get_func(input logic [IW-1:0] word);
    return word[FUNC_HI:FUNC_LO];
  endfunction

endpackage

// File: rtl/pipe_ibuf.sv
// Synchronous show-ahead FIFO used as the instruction prefetch buffer.
// Ports:
// - clk, rst_n : clock, asynchronous active-low reset
// - push/wdata : write an entry (ignored when full unless popping the same cycle)
// - pop        : remove the head entry (ignored when empty)
// - rdata      : head entry, valid whenever !empty
// - empty/full : occupancy flags
// - count      : number of stored entries
module pipe_ibuf #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic            empty,
  output logic            full,
  output logic [CntW-1:0] count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop & ~empty;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push != do_pop) begin
        count_q <= do_push ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ifetch.sv
// Instruction fetch/issue stage in front of the 4-stage ALU pipeline.
// Fetches 24-bit words over a req/ack handshake, buffers them in a prefetch FIFO and issues
// decoded fields with valid/ready. A HALT word ends fetching; the buffer then drains and
// done pulses.
// Ports:
// - clk, rst_n           : clock, asynchronous active-low reset
// - start, base_pc       : begin a program at base_pc (ignored unless idle)
// - imem_req/addr        : fetch request, held with a stable address until imem_ack
// - imem_ack/rdata       : fetch response
// - issue_valid/ready    : downstream handshake
// - func, rd, rs1, rs2, addr : decoded fields of the buffer head (0 when not valid)
// - busy, done           : program in progress / 1-cycle completion pulse
module pipe_ifetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PCW        = 8,
  parameter logic [3:0]  HALT_FUNC  = pipe_pkg::HALT_FUNC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PCW-1:0]         base_pc,
  output logic                   imem_req,
  output logic [PCW-1:0]         imem_addr,
  input  logic                   imem_ack,
  input  logic [pipe_pkg::IW-1:0] imem_rdata,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [3:0]             func,
  output logic [3:0]             rd,
  output logic [3:0]             rs1,
  output logic [3:0]             rs2,
  output logic [7:0]             addr,
  output logic                   busy,
  output logic                   done
);
  import pipe_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e   state_q;
  logic [PCW-1:0] pc_q;
  logic           outstanding_q;
  logic           busy_q, done_q;

  logic           ack_ok, is_halt, push, pop, empty, full, credit_ok;
  logic [IW-1:0]  head;
  logic [CntW-1:0] count, count_next;

  // An ack only counts when a request is actually outstanding.
  assign ack_ok  = imem_ack & outstanding_q;
  assign is_halt = (get_func(imem_rdata) == HALT_FUNC);
  assign push    = ack_ok & ~is_halt;
  assign pop     = issue_valid & issue_ready;

  // Credit is judged on the occupancy after this edge, so a new request can follow an ack
  // immediately without ever overrunning the buffer.
  assign count_next = count + CntW'(push) - CntW'(pop);
  assign credit_ok  = (count_next < CntW'(FIFO_DEPTH));

  pipe_ibuf #(
    .Width(IW),
    .Depth(FIFO_DEPTH)
  ) u_ibuf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .wdata(imem_rdata),
    .rdata(head),
    .empty(empty),
    .full (full),
    .count(count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      outstanding_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StFetch;
            pc_q          <= base_pc;
            outstanding_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        StFetch: begin
          if (ack_ok) begin
            pc_q <= pc_q + 1'b1;
          end
          if (ack_ok && is_halt) begin
            state_q       <= StDrain;
            outstanding_q <= 1'b0;
          end else if (!outstanding_q || ack_ok) begin
            outstanding_q <= credit_ok;
          end
        end
        StDrain: begin
          if (empty) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req    = outstanding_q;
  assign imem_addr   = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign issue_valid = ~empty;
  assign func        = issue_valid ? head[FUNC_HI:FUNC_LO] : '0;
  assign rd          = issue_valid ? head[RD_HI:RD_LO]     : '0;
  assign rs1         = issue_valid ? head[RS1_HI:RS1_LO]   : '0;
  assign rs2         = issue_valid ? head[RS2_HI:RS2_LO]   : '0;
  assign addr        = issue_valid ? head[ADDR_HI:ADDR_LO] : '0;

  logic unused_full;
  assign unused_full = full;

endmodule
